// File: rtl/nubus_mem_pkg.sv
// Shared types and helpers for the card-local memory initiator:
// access sizes, FSM states, lane strobes and alignment checks.
package nubus_mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2,
        ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Byte-lane mask touched by an access of the given size at addr[1:0].
    function automatic logic [3:0] lane_strobe(input size_e size, input logic [1:0] lo);
        case (size)
            BYTE:    lane_strobe = 4'b0001 << lo;
            HALF:    lane_strobe = 4'b0011 << {lo[1], 1'b0};
            WORD:    lane_strobe = 4'hF;
            default: lane_strobe = 4'h0;
        endcase
    endfunction

    // Half must be 2-byte aligned, word must be 4-byte aligned.
    function automatic logic misaligned(input size_e size, input logic [1:0] lo);
        case (size)
            HALF:    misaligned = lo[0];
            WORD:    misaligned = (lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/nubus_mem_lanes.sv
// Combinational lane steering: write strobes and lane-aligned write data
// for the incoming command, and right-aligned extraction of read data for
// the access in flight.
module nubus_mem_lanes
    import nubus_mem_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [1:0]  wr_lane,
    input  logic [31:0] wr_data,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_lane,
    input  logic [31:0] rd_raw,
    output logic [3:0]  strb,
    output logic [31:0] wr_lanes,
    output logic [31:0] rd_data
);

    logic [31:0] wr_rep;
    logic [31:0] rd_shift;

    // Replicate the right-aligned data into every candidate lane, then keep
    // only the strobed lanes so unselected lanes are driven 0.
    always_comb begin
        strb = lane_strobe(size_e'(wr_size), wr_lane);
        case (size_e'(wr_size))
            BYTE:    wr_rep = {4{wr_data[7:0]}};
            HALF:    wr_rep = {2{wr_data[15:0]}};
            default: wr_rep = wr_data;
        endcase
        for (int i = 0; i < 4; i++) begin
            wr_lanes[8*i +: 8] = strb[i] ? wr_rep[8*i +: 8] : 8'h00;
        end
    end

    // Shift the selected lanes down to bit 0 and zero-fill the rest; a legal
    // half has rd_lane[0]=0, so the byte shift also covers the half case.
    always_comb begin
        rd_shift = rd_raw >> {rd_lane, 3'b000};
        case (size_e'(rd_size))
            BYTE:    rd_data = {24'h0, rd_shift[7:0]};
            HALF:    rd_data = {16'h0, rd_shift[15:0]};
            WORD:    rd_data = rd_raw;
            default: rd_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/nubus_mem_master.sv
// Single-outstanding initiator for the card-local memory port. Accepts one
// sized command, runs one memory access under a timeout, returns a single
// response. Every output is a register.
module nubus_mem_master
    import nubus_mem_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic        mem_clk,
    input  logic        mem_resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_valid,
    output logic [3:0]  mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    state_e               state, state_n;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [1:0]           size_q;
    logic [1:0]           lane_q;
    logic                 accept;
    logic                 cmd_bad;
    logic                 tmo_hit;
    logic [3:0]           strb;
    logic [31:0]          wr_lanes;
    logic [31:0]          rd_data;

    assign accept  = cmd_valid && cmd_ready;
    assign cmd_bad = (size_e'(cmd_size) == ILL) || misaligned(size_e'(cmd_size), cmd_addr[1:0]);
    // This ACCESS cycle is the TIMEOUT-th without an acknowledge.
    assign tmo_hit = !mem_ready && (tmo_cnt == TIMEOUT_W'(TIMEOUT - 1));

    nubus_mem_lanes u_lanes (
        .wr_size  (cmd_size),
        .wr_lane  (cmd_addr[1:0]),
        .wr_data  (cmd_wdata),
        .rd_size  (size_q),
        .rd_lane  (lane_q),
        .rd_raw   (mem_rdata),
        .strb     (strb),
        .wr_lanes (wr_lanes),
        .rd_data  (rd_data)
    );

    // State register; reset abandons any access without a response.
    always_ff @(posedge mem_clk or negedge mem_resetn) begin
        if (!mem_resetn) state <= IDLE;
        else             state <= state_n;
    end

    // Next-state: illegal commands bypass memory and go straight to RESP.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = cmd_bad ? RESP : ACCESS;
            ACCESS:  if (mem_ready || tmo_hit) state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered outputs, request capture, response capture and timeout count.
    always_ff @(posedge mem_clk or negedge mem_resetn) begin
        if (!mem_resetn) begin
            cmd_ready <= 1'b0;
            mem_valid <= 1'b0;
            rsp_valid <= 1'b0;
            mem_write <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            size_q    <= 2'd0;
            lane_q    <= 2'd0;
            tmo_cnt   <= '0;
        end else begin
            // Flags follow the next state so they line up with it exactly;
            // ACCESS is always followed by RESP, so mem_valid always gets a
            // low gap before the next access.
            cmd_ready <= (state_n == IDLE);
            mem_valid <= (state_n == ACCESS);
            rsp_valid <= (state_n == RESP);

            if (state == IDLE && accept) begin
                mem_addr  <= {cmd_addr[31:2], 2'b00};
                mem_write <= cmd_write ? strb : 4'h0;
                mem_wdata <= cmd_write ? wr_lanes : 32'h0;
                size_q    <= cmd_size;
                lane_q    <= cmd_addr[1:0];
                tmo_cnt   <= '0;
                if (cmd_bad) begin
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'h0;
                end
            end

            if (state == ACCESS) begin
                if (mem_ready) begin
                    rsp_rdata <= (mem_write != 4'h0) ? 32'h0 : rd_data;
                    rsp_err   <= 1'b0;
                end else if (tmo_hit) begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b1;
                end else if (tmo_cnt != {TIMEOUT_W{1'b1}}) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end
        end
    end

endmodule
